// File: rtl/vc_mem_pkg.sv
// Shared state encoding, CPU sub-request kinds and the bus timeout default
// used by the memory port arbiter.
package vc_mem_pkg;

  localparam int TMO_DEFAULT = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CPU  = 2'd1,
    ST_DMA  = 2'd2,
    ST_DONE = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    OP_FETCH = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } cpu_op_t;

  // Writes beat reads beat fetches when the CPU raises several at once.
  function automatic cpu_op_t cpu_op_sel(input logic wr, input logic rd);
    if (wr) return OP_WRITE;
    if (rd) return OP_READ;
    return OP_FETCH;
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Bus timeout counter: cleared at grant, counts while a transfer is open and
// flags the cycle whose edge would reach TMO.
module mem_arb_timer #(
  parameter int TMO = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (!reset)     count <= '0;
    else if (clear) count <= '0;
    else if (run)   count <= count + 8'd1;
  end

  assign expired = run && (count == 8'(TMO - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between a CPU (fetch/read/write) and a DMA
// master, with alternating tie-break and a bus timeout.
module mem_port_arbiter
  import vc_mem_pkg::*;
#(
  parameter int RV  = 32,
  parameter int VA  = RV,
  parameter int TMO = TMO_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [VA-RV/16-1:0] c_addr,
  input  logic                c_ifetch,
  input  logic [1:0]          c_rstrobe,
  input  logic [RV/8-1:0]     c_wmask,
  input  logic [RV-1:0]       c_wdata,
  output logic                c_idone,
  output logic                c_rdone,
  output logic                c_wdone,
  output logic [RV-1:0]       c_rdata,
  output logic                c_berr,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [VA-RV/16-1:0] d_addr,
  input  logic [RV/8-1:0]     d_wmask,
  input  logic [RV-1:0]       d_wdata,
  output logic                d_ack,
  output logic [RV-1:0]       d_rdata,
  output logic                m_req,
  output logic                m_we,
  output logic [VA-RV/16-1:0] m_addr,
  output logic [RV/8-1:0]     m_wmask,
  output logic [RV-1:0]       m_wdata,
  input  logic                m_ack,
  input  logic [RV-1:0]       m_rdata
);

  arb_state_t state, state_d;
  cpu_op_t    op;
  logic       last_dma;
  logic       c_any, grant_cpu, grant_dma, ack, tmo, in_xfer, expired;

  assign c_any   = c_ifetch || (|c_rstrobe) || (|c_wmask);
  assign in_xfer = (state == ST_CPU) || (state == ST_DMA);

  mem_arb_timer #(.TMO(TMO)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (grant_cpu || grant_dma),
    .run     (in_xfer),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_d;
  end

  // DONE never grants, so a request held through the done pulse is only
  // seen again from IDLE.
  always_comb begin
    state_d   = state;
    grant_cpu = 1'b0;
    grant_dma = 1'b0;
    ack       = 1'b0;
    tmo       = 1'b0;
    case (state)
      ST_IDLE: begin
        grant_cpu = c_any && (!d_req || last_dma);
        grant_dma = d_req && !grant_cpu;
        if (grant_cpu)      state_d = ST_CPU;
        else if (grant_dma) state_d = ST_DMA;
      end
      ST_CPU, ST_DMA: begin
        ack = m_ack;
        tmo = !m_ack && expired;
        if (ack || tmo) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_dma <= 1'b1;
      op       <= OP_FETCH;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wmask  <= '0;
      m_wdata  <= '0;
      c_idone  <= 1'b0;
      c_rdone  <= 1'b0;
      c_wdone  <= 1'b0;
      c_berr   <= 1'b0;
      d_ack    <= 1'b0;
      c_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      c_idone <= 1'b0;
      c_rdone <= 1'b0;
      c_wdone <= 1'b0;
      c_berr  <= 1'b0;
      d_ack   <= 1'b0;
      if (grant_cpu) begin
        last_dma <= 1'b0;
        op       <= cpu_op_sel(|c_wmask, |c_rstrobe);
        m_req    <= 1'b1;
        m_we     <= |c_wmask;
        m_addr   <= c_addr;
        m_wmask  <= (|c_wmask) ? c_wmask : '1;
        m_wdata  <= c_wdata;
      end else if (grant_dma) begin
        last_dma <= 1'b1;
        m_req    <= 1'b1;
        m_we     <= d_we;
        m_addr   <= d_addr;
        m_wmask  <= d_we ? d_wmask : '1;
        m_wdata  <= d_wdata;
      end
      if (ack) begin
        m_req <= 1'b0;
        if (state == ST_CPU) begin
          case (op)
            OP_WRITE: c_wdone <= 1'b1;
            OP_READ:  begin c_rdone <= 1'b1; c_rdata <= m_rdata; end
            default:  begin c_idone <= 1'b1; c_rdata <= m_rdata; end
          endcase
        end else begin
          d_ack   <= 1'b1;
          d_rdata <= m_rdata;
        end
      end
      // A timed-out DMA still gets its ack, with zero data so it cannot
      // mistake stale bus contents for a response.
      if (tmo) begin
        m_req <= 1'b0;
        if (state == ST_CPU) c_berr <= 1'b1;
        else begin
          d_ack   <= 1'b1;
          d_rdata <= '0;
        end
      end
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameters: RV, default 32, datapath width (16 or 32); VA, default RV, virtual address width; TMO, default 255, bus timeout in cycles.
REQ-002 SHALL have ports, clock and reset first:
 clk  in  1  clock
 reset  in  1  reset, synchronous, active-low
 c_addr  in  VA-RV/16  CPU word address
 c_ifetch  in  1  CPU instruction fetch request
 c_rstrobe  in  2  CPU data read request (any bit set)
 c_wmask  in  RV/8  CPU write byte mask (nonzero = write request)
 c_wdata  in  RV  CPU write data
 c_idone, c_rdone, c_wdone  out  1 each  CPU completion pulses
 c_rdata  out  RV  CPU read/fetch data
 c_berr  out  1  CPU bus-timeout pulse
 d_req  in  1  DMA request
 d_we  in  1  DMA write
 d_addr  in  VA-RV/16  DMA word address
 d_wmask  in  RV/8  DMA write mask
 d_wdata  in  RV  DMA write data
 d_ack  out  1  DMA completion pulse
 d_rdata  out  RV  DMA read data
 m_req, m_we  out  1 each  memory request, write
 m_addr  out  VA-RV/16  memory address
 m_wmask  out  RV/8  memory byte mask
 m_wdata  out  RV  memory write data
 m_ack  in  1  memory completion, valid only while m_req=1
 m_rdata  in  RV  memory read data, valid with m_ack

Function
REQ-003 SHALL implement FSM IDLE, CPU, DMA, DONE; m_* outputs SHALL be registered.
REQ-004 IDLE: CPU request (c_ifetch | |c_rstrobe | |c_wmask) or d_req SHALL move to CPU or DMA next edge; m_req SHALL assert that same edge.
REQ-005 Simultaneous CPU and DMA requests SHALL go to the requester not granted last (last_grant bit); a lone requester SHALL be granted immediately.
REQ-006 CPU sub-request priority SHALL be write > read > fetch; m_we=1 and m_wmask=c_wmask for write; otherwise m_we=0 and m_wmask all-ones.
REQ-007 m_addr, m_we, m_wmask, m_wdata SHALL be latched at grant and held stable until m_ack.
REQ-008 On m_ack in CPU/DMA: m_req SHALL drop next edge; state SHALL go to DONE; exactly one done pulse (c_idone, c_rdone, c_wdone or d_ack, matching the granted type) SHALL assert for the single DONE cycle; c_rdata/d_rdata SHALL hold the registered m_rdata from that edge until the next completion.
REQ-009 DONE SHALL last exactly one cycle, grant nothing and return to IDLE, so a request still held in the done cycle is never re-issued.
REQ-010 An 8-bit timeout counter SHALL clear at grant and increment each cycle in CPU/DMA; reaching TMO without m_ack SHALL drop m_req, enter DONE and pulse c_berr (CPU grant) or d_ack (DMA grant; d_rdata=0) instead of the normal done.
REQ-011 m_ack outside CPU/DMA SHALL be ignored.
REQ-012 Minimum transaction occupancy SHALL be 3 cycles (grant, ack, DONE) for a zero-wait memory.

Reset
REQ-013 reset=0 at a clock edge SHALL force state IDLE, last_grant=DMA (CPU wins first tie), counter 0, m_req=0, m_we=0, m_wmask=0, all done pulses and c_berr=0, c_rdata=d_rdata=0.
REQ-014 Reset during CPU/DMA SHALL abandon the transaction with no done pulse; a late m_ack SHALL be ignored.

Structure
REQ-015 State encoding and the TMO default SHALL live in shared package vc_mem_pkg.
REQ-016 The timeout counter SHALL be sub-module mem_arb_timer (clear, run, expired); all else SHALL be flat.

Verification
REQ-017 CPU fetch c_addr=0x100, m_ack on the first m_req cycle, m_rdata=0x12345678 -> m_req 1 cycle, c_idone pulse 1 cycle later, c_rdata=0x12345678.
REQ-018 c_wmask=4'b0100 and d_req both raised out of reset -> CPU first (m_we=1, m_wmask=4'b0100), then DMA; next tie -> CPU again.
REQ-019 c_rstrobe and c_wmask both nonzero -> write issued first, c_wdone pulses; c_rdone absent for that transaction.
REQ-020 DMA read, m_ack never asserted -> m_req drops after 255 cycles, d_ack pulses, d_rdata=0; c_berr stays 0.
REQ-021 Reset asserted 2 cycles into a 5-wait-state CPU read, m_ack on the following cycle -> no c_rdone, state IDLE, m_req=0.
REQ-022 CPU holds c_ifetch through the c_idone cycle -> exactly one memory transaction per hold, with the next issued no earlier than 1 cycle after DONE.
